// File: rtl/restoring_divider_32bit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU; optional DIV_ERR_FLAGS_EN adds div_zero/div_ovf.
// Latency: done after edge WIDTH+2 from the start edge; divide-by-zero and signed overflow after edge 1.
// Backpressure: start is sampled only in IDLE and ignored while busy; results hold until the next accepted start.
module restoring_divider_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done
`ifdef DIV_ERR_FLAGS_EN
  ,
  output logic             div_zero,
  output logic             div_ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgn_q, sgn_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef DIV_ERR_FLAGS_EN
  logic             zero_pend_q, zero_pend_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             div_zero_q, div_zero_d;
  logic             div_ovf_q, div_ovf_d;
`endif

  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic             div_by_zero;
  logic             sgn_ovf;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    cnt_d       = cnt_q;
    sgn_d       = sgn_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    done_d      = 1'b0;
`ifdef DIV_ERR_FLAGS_EN
    zero_pend_d = zero_pend_q;
    ovf_pend_d  = ovf_pend_q;
    div_zero_d  = div_zero_q;
    div_ovf_d   = div_ovf_q;
`endif

    dividend_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    divisor_mag  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    div_by_zero  = (divisor == '0);
    sgn_ovf      = is_signed && (dividend == MOST_NEG) && (divisor == '1);

    // The shifted remainder can exceed WIDTH bits in unsigned mode, so the
    // subtraction keeps one extra bit above the sign to avoid aliasing.
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, dvs_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          sgn_d       = is_signed;
          neg_quo_d   = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_rem_d   = dividend[WIDTH-1];
          dvs_d       = divisor_mag;
          quo_d       = dividend_mag;
          rem_d       = '0;
          cnt_d       = CW'(WIDTH);
          quotient_d  = '0;
          remainder_d = '0;
          state_d     = CALC;
`ifdef DIV_ERR_FLAGS_EN
          zero_pend_d = div_by_zero;
          ovf_pend_d  = sgn_ovf;
          div_zero_d  = 1'b0;
          div_ovf_d   = 1'b0;
`endif
          if (div_by_zero) begin
            quo_d   = '1;
            rem_d   = dividend;
            state_d = DONE;
          end else if (sgn_ovf) begin
            quo_d   = dividend;
            rem_d   = '0;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        if (!trial[WIDTH+1]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        if (sgn_q && neg_quo_q) quo_d = -quo_q;
        if (sgn_q && neg_rem_q) rem_d = -rem_q;
        state_d = DONE;
      end
      DONE: begin
        quotient_d  = quo_q;
        remainder_d = rem_q;
        done_d      = 1'b1;
        state_d     = IDLE;
`ifdef DIV_ERR_FLAGS_EN
        div_zero_d  = zero_pend_q;
        div_ovf_d   = ovf_pend_q;
`endif
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      cnt_q       <= '0;
      sgn_q       <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DIV_ERR_FLAGS_EN
      zero_pend_q <= 1'b0;
      ovf_pend_q  <= 1'b0;
      div_zero_q  <= 1'b0;
      div_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      cnt_q       <= cnt_d;
      sgn_q       <= sgn_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef DIV_ERR_FLAGS_EN
      zero_pend_q <= zero_pend_d;
      ovf_pend_q  <= ovf_pend_d;
      div_zero_q  <= div_zero_d;
      div_ovf_q   <= div_ovf_d;
`endif
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef DIV_ERR_FLAGS_EN
  assign div_zero  = div_zero_q;
  assign div_ovf   = div_ovf_q;
`endif

endmodule

// File: tb/tb_restoring_divider_32bit.sv
// Scoreboard bench for restoring_divider_32bit: stimulus pushes model results, a monitor pops them on done.
module tb_restoring_divider_32bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
`ifdef DIV_ERR_FLAGS_EN
  logic        div_zero;
  logic        div_ovf;
`endif

  restoring_divider_32bit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done)
`ifdef DIV_ERR_FLAGS_EN
    ,
    .div_zero  (div_zero),
    .div_ovf   (div_ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          cyc;
    logic        z;
    logic        o;
  } exp_t;

  exp_t exp_q[$];
  exp_t last;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, with the two RISC-V special cases.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 32'd0;
    end else if (s) begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Called at a negedge with the DUT idle (or in its done cycle); returns at the negedge after edge 0.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    logic special;
    model(a, b, s, e.q, e.r);
    e.z     = (b == 32'd0);
    e.o     = s && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    special = e.z || e.o;
    e.cyc   = cyc + 1 + (special ? 1 : 34);
    exp_q.push_back(e);
    last      = e;
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no_done required=done_within_60_cycles");
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done required=no_done cyc=%0d", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_quotient", quotient, e.q);
        chk("sb_remainder", remainder, e.r);
        chk("sb_latency", cyc, e.cyc);
`ifdef DIV_ERR_FLAGS_EN
        chk("sb_div_zero", div_zero, e.z);
        chk("sb_div_ovf", div_ovf, e.o);
`endif
      end
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
  } dir_t;

  dir_t dir_tab[8] = '{
    '{32'd100,        32'd7,          1'b1, 32'd14,         32'd2},
    '{32'hFFFF_FF9C,  32'd7,          1'b1, 32'hFFFF_FFF2,  32'hFFFF_FFFE},
    '{32'd100,        32'hFFFF_FFF9,  1'b1, 32'hFFFF_FFF2,  32'd2},
    '{32'hFFFF_FFFF,  32'd2,          1'b0, 32'h7FFF_FFFF,  32'd1},
    '{32'hFFFF_FFFF,  32'd2,          1'b1, 32'd0,          32'hFFFF_FFFF},
    '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5},
    '{32'd5,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd5},
    '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0}
  };

  initial begin
    int busy_cnt;
    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Busy window for a normal division spans edges 0..33.
    issue(32'd100, 32'd7, 1'b1);
    busy_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (!busy) break;
      busy_cnt++;
      @(negedge clk);
    end
    chk("busy_cycles", busy_cnt, 34);
    chk("done_after_busy", done, 1'b1);
    @(negedge clk);

    foreach (dir_tab[i]) begin
      issue(dir_tab[i].a, dir_tab[i].b, dir_tab[i].s);
      wait_done();
      chk("dir_quotient", quotient, dir_tab[i].q);
      chk("dir_remainder", remainder, dir_tab[i].r);
      @(negedge clk);
    end

    // start re-pulsed mid-operation is ignored; start in the done cycle is accepted.
    issue(32'd100, 32'd7, 1'b1);
    repeat (9) @(negedge clk);
    dividend  = 32'd9;
    divisor   = 32'd3;
    is_signed = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("repulse_quotient", quotient, 32'd14);
    chk("repulse_remainder", remainder, 32'd2);
    issue(32'd9, 32'd3, 1'b0);
    wait_done();
    chk("donecycle_quotient", quotient, 32'd3);
    chk("donecycle_remainder", remainder, 32'd0);
    @(negedge clk);

    // Reset at edge 15 aborts the division with no done pulse.
    issue(32'd100, 32'd7, 1'b1);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    repeat (40) @(negedge clk);
    issue(32'd42, 32'd5, 1'b0);
    wait_done();
    chk("post_abort_quotient", quotient, 32'd8);
    chk("post_abort_remainder", remainder, 32'd2);
    @(negedge clk);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      int          sel;
      s   = 1'(($urandom_range(0, 1)));
      a   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'($urandom_range(1, 15));
        4: begin a = 32'($urandom_range(0, 50)); b = $urandom; end
        default: b = $urandom;
      endcase
      issue(a, b, s);
      wait_done();
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 4)) @(negedge clk);
        chk("hold_quotient", quotient, last.q);
        chk("hold_remainder", remainder, last.r);
      end
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/restoring_divider_32bit.md
Name: restoring_divider_32bit

Overview:
- Sequential restoring divider, radix-2, one quotient bit per clock.
- Complements the Booth radix-4 multiplier in the PE datapath; serves RISC-V M-extension DIV/DIVU/REM/REMU.
- Uses the same start/done handshake as the multiplier: one start pulse, one done pulse, results held after completion.

Parameters:
- WIDTH, 32, operand/result width in bits; must be even and >= 4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request new division; sampled only in IDLE.
- is_signed  input  1  1 = DIV/REM semantics (two's complement), 0 = DIVU/REMU; sampled with start.
- dividend  input  WIDTH  numerator; sampled with start.
- divisor  input  WIDTH  denominator; sampled with start.
- quotient  output  WIDTH  registered quotient.
- remainder  output  WIDTH  registered remainder; sign follows dividend.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; results valid in the same cycle.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE; quotient=0, remainder=0, done=0, busy=0; all internal registers cleared. Reset wins over every other event, including reset mid-operation; an aborted division never raises done.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - done=0 every cycle except the cycle following DONE.
  - On start=1: latch operands and is_signed; clear quotient/remainder to 0.
  - Signed mode: latch magnitudes |dividend| and |divisor|; record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend).
  - Load iteration counter = WIDTH, partial remainder = 0.
  - Next state CALC, except for special cases (below), which go directly to DONE.
- CALC, one iteration per cycle:
  - Shift {rem,quo} left by 1.
  - trial = rem - divisor_mag, computed at WIDTH+1 bits.
  - If trial >= 0: rem = trial, quo LSB = 1; else rem is unchanged, quo LSB = 0.
  - Counter decrements; when it reaches 0 the next state is FIXUP. CALC lasts exactly WIDTH cycles.
- FIXUP: signed mode applies two's-complement negation to the quotient if neg_q and to the remainder if neg_r; unsigned mode passes both through. Next state DONE.
- DONE: register quotient/remainder outputs, done=1 for exactly one cycle, next state IDLE.
- Latency (edge that samples start = edge 0):
  - Normal case: done high after edge WIDTH+2 (34 for WIDTH=32).
  - Special cases: done high after edge 1.
- Special cases, decided in IDLE and taking priority over CALC:
  - Divide by zero (divisor==0, either mode): quotient = all ones, remainder = dividend.
  - Signed overflow (dividend = most-negative, divisor = -1, is_signed=1): quotient = dividend, remainder = 0.
- start while busy=1 is ignored; it is neither queued nor does it corrupt the operation in flight. start in the same cycle done is high is accepted, because the state is already IDLE.
- Operand inputs may change freely after the start cycle.
- Outputs hold the last result until the next accepted start.

Optional Feature:
- Macro: DIV_ERR_FLAGS_EN.
- Defined: adds two 1-bit outputs, div_zero and div_ovf.
  - Registered in DONE alongside the results; high together with done for the special cases.
  - Otherwise hold the last value; cleared on reset and on an accepted start.
- Undefined: the ports do not exist; special-case results are unchanged.

Test Plan:
- Signed 100 / 7 -> quotient=14, remainder=2, done pulse after edge 34, busy high edges 0..33.
- Signed -100 / 7 -> quotient=0xFFFFFFF2, remainder=0xFFFFFFFE. Signed 100 / -7 -> quotient=0xFFFFFFF2, remainder=2.
- Unsigned 0xFFFFFFFF / 2 -> quotient=0x7FFFFFFF, remainder=1. The same operands in signed mode (-1 / 2) -> quotient=0, remainder=0xFFFFFFFF.
- Special cases:
  - 5 / 0 in both modes -> quotient=0xFFFFFFFF, remainder=5, done after edge 1.
  - 0x80000000 / 0xFFFFFFFF signed -> quotient=0x80000000, remainder=0, done after edge 1.
  - With DIV_ERR_FLAGS_EN: div_zero and div_ovf pulse respectively.
- start re-pulsed at edge 10 with 9 / 3 during 100 / 7 -> result stays 14/2 at edge 34. A start in the done cycle with 9 / 3 -> quotient=3, remainder=0, 34 edges later.
- rst=1 at edge 15 mid-division -> state IDLE, outputs 0, no done pulse. A subsequent start with 42 / 5 -> quotient=8, remainder=2.
